// File: rtl/lbuf_fetch_ctrl_pkg.sv
// Shared state encodings and default frame geometry for the linebuffer fill path.
// Also used by the output controller.
package lbuf_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_FRAME = 2'd0,
      ST_REQ        = 2'd1,
      ST_BURST      = 2'd2,
      ST_FULL       = 2'd3
   } fetch_state_e;

   localparam int unsigned DEF_FB_ADDR_WIDTH   = 32;
   localparam int unsigned DEF_FB_BASE         = 0;
   localparam int unsigned DEF_LINE_STRIDE     = 640;
   localparam int unsigned DEF_WORDS_PER_LINE  = 160;
   localparam int unsigned DEF_LINES_PER_FRAME = 480;
   localparam int unsigned DEF_LB_ADDR_WIDTH   = 9;

endpackage

// File: rtl/lbuf_fetch_ctrl_if.sv
// Framebuffer read port plus linebuffer write port of the fill controller.
// The master side is the fill controller; the slave side is memory/linebuffer.
interface lbuf_fetch_ctrl_if
   import lbuf_fetch_ctrl_pkg::*;
#(
   parameter int unsigned FB_ADDR_WIDTH = DEF_FB_ADDR_WIDTH,
   parameter int unsigned LB_ADDR_WIDTH = DEF_LB_ADDR_WIDTH
) ();

   // Handshake: mem_rd_req/mem_rd_addr stay stable until mem_rd_ack is sampled
   // high; mem_rd_valid qualifies each beat with no back-pressure; lb_we
   // qualifies lb_waddr/lb_wdata for exactly one cycle per written word.
   logic                     mem_rd_req;
   logic [FB_ADDR_WIDTH-1:0] mem_rd_addr;
   logic                     mem_rd_ack;
   logic                     mem_rd_valid;
   logic [31:0]              mem_rd_data;
   logic                     lb_we;
   logic [LB_ADDR_WIDTH-1:0] lb_waddr;
   logic [31:0]              lb_wdata;

   modport master (
      output mem_rd_req, mem_rd_addr,
      input  mem_rd_ack, mem_rd_valid, mem_rd_data,
      output lb_we, lb_waddr, lb_wdata
   );

   modport slave (
      input  mem_rd_req, mem_rd_addr,
      output mem_rd_ack, mem_rd_valid, mem_rd_data,
      input  lb_we, lb_waddr, lb_wdata
   );

endinterface

// File: rtl/lbuf_fetch_ctrl_rise_detect.sv
// Registered previous value of a level input plus a same-cycle rising-edge flag.
module lbuf_fetch_ctrl_rise_detect (
   input  logic pclk,
   input  logic reset_n,
   input  logic level,
   output logic rise
);

   logic prev;

   always_ff @(posedge pclk) begin
      if (!reset_n) prev <= 1'b0;
      else          prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/lbuf_fetch_ctrl.sv
// Double-buffered linebuffer fill controller: one framebuffer burst per line into
// the back bank, bank swap on req_line, restart at frame base on req_frame.
module lbuf_fetch_ctrl
   import lbuf_fetch_ctrl_pkg::*;
#(
   parameter int unsigned FB_ADDR_WIDTH   = DEF_FB_ADDR_WIDTH,
   parameter int unsigned FB_BASE         = DEF_FB_BASE,
   parameter int unsigned LINE_STRIDE     = DEF_LINE_STRIDE,
   parameter int unsigned WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
   parameter int unsigned LINES_PER_FRAME = DEF_LINES_PER_FRAME,
   parameter int unsigned LB_ADDR_WIDTH   = DEF_LB_ADDR_WIDTH
) (
   input  logic                 pclk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 req_line,
   input  logic                 req_frame,
   lbuf_fetch_ctrl_if.master    bus,
   output logic                 lb_rd_bank,
   output logic                 underrun,
   output logic [9:0]           fetch_idx,
   output fetch_state_e         dbg_state
);

   localparam int unsigned WW = LB_ADDR_WIDTH - 1;
   localparam logic [FB_ADDR_WIDTH-1:0] BASE_A    = FB_ADDR_WIDTH'(FB_BASE);
   localparam logic [FB_ADDR_WIDTH-1:0] STRIDE_A  = FB_ADDR_WIDTH'(LINE_STRIDE);
   localparam logic [WW-1:0]            LAST_WORD = WW'(WORDS_PER_LINE - 1);
   localparam logic [9:0]               LAST_LINE = 10'(LINES_PER_FRAME - 1);

   fetch_state_e             state, state_n;
   logic                     line_rise, frame_rise;
   logic [FB_ADDR_WIDTH-1:0] line_addr, addr_n;
   logic [WW-1:0]            wcount;
   logic                     restart_pend;
   logic                     load_base, step_line, swap, start_burst, beat;
   logic                     set_pend, clr_pend, underrun_n;

   lbuf_fetch_ctrl_rise_detect u_line_rise (
      .pclk(pclk), .reset_n(reset_n), .level(req_line), .rise(line_rise)
   );

   lbuf_fetch_ctrl_rise_detect u_frame_rise (
      .pclk(pclk), .reset_n(reset_n), .level(req_frame), .rise(frame_rise)
   );

   assign dbg_state = state;

   always_ff @(posedge pclk) begin
      if (!reset_n) state <= ST_WAIT_FRAME;
      else          state <= state_n;
   end

   always_comb begin
      state_n     = state;
      load_base   = 1'b0;
      step_line   = 1'b0;
      swap        = 1'b0;
      start_burst = 1'b0;
      beat        = 1'b0;
      set_pend    = 1'b0;
      clr_pend    = 1'b0;
      underrun_n  = 1'b0;
      unique case (state)
         ST_WAIT_FRAME: begin
            if (frame_rise && enable) begin
               load_base = 1'b1;
               clr_pend  = 1'b1;
               state_n   = ST_REQ;
            end
         end
         ST_REQ: begin
            set_pend   = frame_rise;
            underrun_n = line_rise;
            if (bus.mem_rd_ack) begin
               start_burst = 1'b1;
               state_n     = ST_BURST;
            end
         end
         ST_BURST: begin
            set_pend   = frame_rise;
            underrun_n = line_rise;
            beat       = bus.mem_rd_valid;
            // A restart seen on the final beat itself is honoured immediately.
            if (bus.mem_rd_valid && wcount == LAST_WORD) begin
               if (restart_pend || frame_rise) begin
                  load_base = 1'b1;
                  clr_pend  = 1'b1;
                  state_n   = ST_REQ;
               end else begin
                  state_n = ST_FULL;
               end
            end
         end
         ST_FULL: begin
            swap = line_rise;
            if (frame_rise) begin
               load_base = 1'b1;
               state_n   = ST_REQ;
            end else if (line_rise) begin
               if (fetch_idx == LAST_LINE) begin
                  state_n = ST_WAIT_FRAME;
               end else begin
                  step_line = 1'b1;
                  state_n   = ST_REQ;
               end
            end
         end
      endcase
      addr_n = line_addr;
      if (load_base)      addr_n = BASE_A;
      else if (step_line) addr_n = line_addr + STRIDE_A;
   end

   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         line_addr       <= BASE_A;
         fetch_idx       <= 10'd0;
         lb_rd_bank      <= 1'b0;
         wcount          <= '0;
         restart_pend    <= 1'b0;
         underrun        <= 1'b0;
         bus.mem_rd_req  <= 1'b0;
         bus.mem_rd_addr <= '0;
         bus.lb_we       <= 1'b0;
         bus.lb_waddr    <= '0;
         bus.lb_wdata    <= '0;
      end else begin
         line_addr <= addr_n;
         if (load_base)      fetch_idx <= 10'd0;
         else if (step_line) fetch_idx <= fetch_idx + 10'd1;
         if (swap) lb_rd_bank <= ~lb_rd_bank;
         if (start_burst) wcount <= '0;
         else if (beat)   wcount <= wcount + 1'b1;
         if (clr_pend)      restart_pend <= 1'b0;
         else if (set_pend) restart_pend <= 1'b1;
         underrun        <= underrun_n;
         bus.mem_rd_req  <= (state_n == ST_REQ);
         bus.mem_rd_addr <= (state_n == ST_REQ) ? addr_n : '0;
         // Beats always land in the bank the output side is not reading.
         bus.lb_we <= beat;
         if (beat) begin
            bus.lb_waddr <= {~lb_rd_bank, wcount};
            bus.lb_wdata <= bus.mem_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_lbuf_fetch_ctrl.sv
// Randomized scoreboard bench for lbuf_fetch_ctrl; a short line keeps a whole
// 480-line frame affordable in cycles.
module tb_lbuf_fetch_ctrl;
  import lbuf_fetch_ctrl_pkg::*;

  localparam int WPL    = 24;
  localparam int LPF    = 480;
  localparam int STRIDE = 640;
  localparam int BASE   = 0;
  localparam int AW     = 32;
  localparam int LW     = 9;
  localparam int WR_W   = 32 + LW + 32;
  localparam int P_IDLE = 0, P_REQ = 1, P_BURST = 2, P_FULL = 3;

  // clock / reset
  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic req_line = 1'b0;
  logic req_frame = 1'b0;
  logic lb_rd_bank, underrun;
  logic [9:0] fetch_idx;
  fetch_state_e dbg_state;
  int cyc = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  lbuf_fetch_ctrl_if #(.FB_ADDR_WIDTH(AW), .LB_ADDR_WIDTH(LW)) bus ();

  lbuf_fetch_ctrl #(
    .FB_ADDR_WIDTH(AW), .FB_BASE(BASE), .LINE_STRIDE(STRIDE),
    .WORDS_PER_LINE(WPL), .LINES_PER_FRAME(LPF), .LB_ADDR_WIDTH(LW)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .enable(enable),
    .req_line(req_line), .req_frame(req_frame), .bus(bus),
    .lb_rd_bank(lb_rd_bank), .underrun(underrun),
    .fetch_idx(fetch_idx), .dbg_state(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass = 0;
  logic [WR_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference model: the fill sequence as described, line by line
  int m_phase = P_IDLE;
  int m_beat = 0;
  int m_idx = 0;
  logic m_bank = 1'b0, m_pend = 1'b0, m_und = 1'b0;
  logic m_prev_ln = 1'b0, m_prev_fr = 1'b0;
  logic [AW-1:0] m_addr = AW'(BASE);

  logic s_req = 1'b0, s_bank = 1'b0, s_und = 1'b0, mon_on = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [9:0] s_idx = '0;

  int ack_pct = 100, vld_pct = 100, stray_pct = 0;

  task automatic new_line(input logic [AW-1:0] a, input int idx);
    m_addr = a;
    m_idx = idx;
    m_phase = P_REQ;
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_beat = 0; m_idx = 0; m_bank = 1'b0; m_pend = 1'b0;
    m_addr = AW'(BASE); m_prev_ln = 1'b0; m_prev_fr = 1'b0;
  endtask

  // driver: one clock per call; decides inputs for the coming edge
  task automatic step();
    logic ack, vld, lr, frr;
    logic [31:0] dat;
    s_req = (m_phase == P_REQ);
    s_addr = m_addr;
    s_bank = m_bank;
    s_idx = 10'(m_idx);
    s_und = m_und;
    mon_on = 1'b1;
    ack = (m_phase == P_REQ) && ($urandom_range(99) < ack_pct);
    vld = (m_phase == P_BURST) ? ($urandom_range(99) < vld_pct) : ($urandom_range(99) < stray_pct);
    dat = $urandom();
    bus.mem_rd_ack = ack;
    bus.mem_rd_valid = vld;
    bus.mem_rd_data = dat;
    m_und = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else begin
      lr = req_line && !m_prev_ln;
      frr = req_frame && !m_prev_fr;
      case (m_phase)
        P_IDLE: if (frr && enable) begin m_pend = 1'b0; new_line(AW'(BASE), 0); end
        P_REQ: begin
          if (frr) m_pend = 1'b1;
          if (lr) m_und = 1'b1;
          if (ack) begin m_phase = P_BURST; m_beat = 0; end
        end
        P_BURST: begin
          if (frr) m_pend = 1'b1;
          if (lr) m_und = 1'b1;
          if (vld) begin
            exp_q.push_back({32'(cyc + 1), ~m_bank, 8'(m_beat), dat});
            m_beat++;
            if (m_beat == WPL) begin
              if (m_pend) begin m_pend = 1'b0; new_line(AW'(BASE), 0); end
              else m_phase = P_FULL;
            end
          end
        end
        default: begin
          if (lr) m_bank = ~m_bank;
          if (frr) new_line(AW'(BASE), 0);
          else if (lr) begin
            if (m_idx == LPF - 1) m_phase = P_IDLE;
            else new_line(m_addr + AW'(STRIDE), m_idx + 1);
          end
        end
      endcase
      m_prev_ln = req_line;
      m_prev_fr = req_frame;
    end
    @(posedge pclk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic line_pulse();
    req_line = 1'b1; step(); step(); req_line = 1'b0; step();
  endtask

  task automatic frame_pulse();
    req_frame = 1'b1; step(); step(); req_frame = 1'b0; step();
  endtask

  task automatic wait_phase(input int p, input int budget, input string what);
    int k = 0;
    while (m_phase != p && k < budget) begin step(); k++; end
    n_checks++;
    if (m_phase == p) n_pass++;
    else $display("FAIL timeout %s: phase %0d after %0d cycles, needed %0d", what, m_phase, budget, p);
  endtask

  task automatic wait_beat(input int n, input int budget);
    int k = 0;
    while (!(m_phase == P_BURST && m_beat >= n) && k < budget) begin step(); k++; end
    n_checks++;
    if (m_phase == P_BURST && m_beat >= n) n_pass++;
    else $display("FAIL timeout beat %0d: got %0d after %0d cycles", n, m_beat, budget);
  endtask

  // monitor: compares DUT outputs every cycle, pops writes as they appear
  logic prev_req_seen = 1'b0;
  int req_rises = 0, und_pulses = 0;
  logic [WR_W-1:0] mon_e;
  logic mon_due;

  always @(negedge pclk) begin
    if (mon_on) begin
      check("mem_rd_req", bus.mem_rd_req, s_req);
      if (s_req) check("mem_rd_addr", bus.mem_rd_addr, s_addr);
      check("lb_rd_bank", lb_rd_bank, s_bank);
      check("fetch_idx", fetch_idx, s_idx);
      check("underrun", underrun, s_und);
      mon_due = 1'b0;
      if (exp_q.size() > 0) begin
        mon_e = exp_q[0];
        mon_due = (mon_e[WR_W-1 -: 32] == 32'(cyc));
      end
      check("lb_we", bus.lb_we, mon_due);
      if (mon_due) begin
        void'(exp_q.pop_front());
        if (bus.lb_we) check("lb_write", {bus.lb_waddr, bus.lb_wdata}, mon_e[LW+31:0]);
      end
      if (bus.mem_rd_req && !prev_req_seen) req_rises++;
      prev_req_seen = bus.mem_rd_req;
      if (underrun) und_pulses++;
    end
  end

  // stimulus
  int r0, u0;
  initial begin
    bus.mem_rd_ack = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data = '0;
    @(posedge pclk);
    #2;
    run(3);
    reset_n = 1'b1;
    run(2);

    // enable low blocks the frame start
    r0 = req_rises;
    frame_pulse();
    run(10);
    check("disabled_no_req", 64'(req_rises - r0), 0);
    enable = 1'b1;
    frame_pulse();
    wait_phase(P_FULL, 100, "first line");
    line_pulse();
    wait_phase(P_FULL, 100, "second line");

    // whole frame with zero-stall memory
    r0 = req_rises;
    u0 = und_pulses;
    frame_pulse();
    for (int l = 0; l < LPF; l++) begin
      wait_phase(P_FULL, 100, "frame line");
      line_pulse();
    end
    run(3);
    check("frame_requests", 64'(req_rises - r0), LPF);
    check("frame_underruns", 64'(und_pulses - u0), 0);
    check("frame_end_idx", fetch_idx, LPF - 1);
    check("frame_end_state", dbg_state, ST_WAIT_FRAME);

    // stalled beats: line boundary arrives before the back bank is full
    u0 = und_pulses;
    ack_pct = 50;
    vld_pct = 30;
    frame_pulse();
    wait_beat(5, 200);
    line_pulse();
    check("underrun_count", 64'(und_pulses - u0), 1);
    wait_phase(P_FULL, 400, "stalled line");
    line_pulse();

    // frame restart mid-burst finishes the burst, then refetches line 0
    ack_pct = 100;
    vld_pct = 100;
    wait_beat(10, 100);
    frame_pulse();
    wait_phase(P_FULL, 200, "restart line");
    check("restart_idx", fetch_idx, 0);

    // coincident line and frame rises while full
    req_line = 1'b1; req_frame = 1'b1;
    step(); step();
    req_line = 1'b0; req_frame = 1'b0;
    step();
    wait_phase(P_FULL, 100, "coincident");

    // reset mid-burst with stray beats afterwards
    line_pulse();
    wait_beat(12, 100);
    stray_pct = 100;
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    r0 = req_rises;
    line_pulse();
    line_pulse();
    run(5);
    check("post_reset_no_req", 64'(req_rises - r0), 0);
    stray_pct = 0;
    frame_pulse();
    wait_phase(P_FULL, 100, "after reset");

    // random soak
    for (int i = 0; i < 80; i++) begin
      ack_pct = $urandom_range(100, 20);
      vld_pct = $urandom_range(100, 20);
      stray_pct = $urandom_range(30, 0);
      enable = ($urandom_range(3, 0) != 0);
      case ($urandom_range(3, 0))
        0: line_pulse();
        1: frame_pulse();
        2: run($urandom_range(40, 1));
        default: begin
          req_line = 1'b1; req_frame = 1'b1;
          step();
          req_line = 1'b0; req_frame = 1'b0;
          step();
        end
      endcase
    end

    ack_pct = 0;
    vld_pct = 0;
    stray_pct = 0;
    run(4);
    check("exp_q_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lbuf_fetch_ctrl.md
# lbuf_fetch_ctrl

Double-buffered linebuffer fill controller between the framebuffer memory read port and the output video linebuffer. It sequences one burst read per display line from the framebuffer into the back half of a two-bank linebuffer. It swaps banks when the output controller signals end of line (`req_line`) and restarts at the frame base on `req_frame`. This lets the output controller read one bank at pixel rate while the next line is fetched into the other.

## Interface
- `FB_ADDR_WIDTH`, 32: framebuffer byte-address width.
- `FB_BASE`, 0: byte address of line 0 of the frame.
- `LINE_STRIDE`, 640: byte distance between consecutive lines.
- `WORDS_PER_LINE`, 160: 32-bit words per display line (640 px / 4).
- `LINES_PER_FRAME`, 480: active lines per frame.
- `LB_ADDR_WIDTH`, 9: linebuffer write address width. MSB is the bank; the low bits are the word index and must hold `WORDS_PER_LINE-1`.
- `pclk` in 1: pixel clock; the block is single-clock.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: permits frame start.
- `req_line` in 1: level; high during horizontal blank after each active line.
- `req_frame` in 1: level; high during the last active line.
- `mem_rd_req` out 1: burst request.
- `mem_rd_addr` out FB_ADDR_WIDTH: burst start byte address.
- `mem_rd_ack` in 1: request accepted.
- `mem_rd_valid` in 1: read beat valid.
- `mem_rd_data` in 32: read beat data, first pixel in bits [31:24].
- `lb_we` out 1: linebuffer write enable.
- `lb_waddr` out LB_ADDR_WIDTH: `{bank, word}`.
- `lb_wdata` out 32: linebuffer write data.
- `lb_rd_bank` out 1: bank the output controller reads; it forms the MSB of the read address.
- `underrun` out 1: one-cycle pulse when a line was needed but the back bank was incomplete.
- `fetch_idx` out 10: line index currently held or being fetched in the back bank.

## Operation
- Edge detection: `req_line` and `req_frame` each have a registered previous value.
  - A rise is current=1 with previous=0.
  - Rises are acted on at the same pclk edge that samples them.
- States:
  - WAIT_FRAME: idle.
  - REQ: `mem_rd_req`=1, `mem_rd_addr`=line address.
  - BURST: counting beats.
  - FULL: back bank complete, waiting for swap.
- WAIT_FRAME transitions:
  - A `req_frame` rise with `enable`=1 sets line address to `FB_BASE` and `fetch_idx` to 0, then goes to REQ.
  - `req_line` rises are ignored here; no underrun.
- REQ transitions:
  - Hold `mem_rd_req` until `mem_rd_ack`=1 is sampled.
  - Then deassert the request, clear the word count and go to BURST.
- BURST transitions:
  - Each `mem_rd_valid` beat is written to `{~lb_rd_bank, wcount}` and increments `wcount`.
  - The beat with `wcount`=`WORDS_PER_LINE-1` ends the burst and goes to FULL.
  - If a frame restart is pending, it instead goes to REQ with address `FB_BASE` and index 0, and the pending flag clears.
- FULL transitions on a `req_line` rise:
  - Toggle `lb_rd_bank`.
  - If `fetch_idx`=`LINES_PER_FRAME-1`, go to WAIT_FRAME.
  - Otherwise add `LINE_STRIDE` to the line address (modulo 2^`FB_ADDR_WIDTH`), increment `fetch_idx` and go to REQ.
- `req_frame` rise in FULL: reload `FB_BASE`/0 and go to REQ without a swap.
- `req_frame` rise in REQ or BURST: set frame-restart pending. In-flight bursts are never aborted.
- `req_line` rise in REQ or BURST: pulse `underrun`, no swap. The fetch continues, and the swap happens at the next `req_line` rise once FULL.
- Simultaneous `req_line` and `req_frame` rises in FULL: swap first, then reload `FB_BASE`/0 and go to REQ.
- `mem_rd_valid` outside BURST is ignored.
- `enable` is sampled only in WAIT_FRAME.

## Timing
- Reset values: state WAIT_FRAME, all outputs 0, internal address=`FB_BASE`, `fetch_idx`=0, edge registers cleared.
- Reset mid-burst discards the burst. The memory port shares the same reset.
- `lb_we`/`lb_waddr`/`lb_wdata` are registered: one cycle latency from `mem_rd_valid`.
- `mem_rd_req` asserts the cycle after entry to REQ and drops the cycle after ack.
- `lb_rd_bank` changes one cycle after the first high sample of `req_line`.
- The final beat write and the swap can coincide. The write lands in the old back bank, and the swap then takes effect on the following `req_line` rise.
- Fetch budget: one line period (800 pclk at defaults) per line. Beats may stall arbitrarily.

## Structure
- Shared header `lbuf_defs.vh`: state encodings (2-bit) and default geometry constants (640×480, 160 words, 640-byte stride), shared with the output controller.
- Natural sub-module: `rise_detect` (registered previous value plus rising-edge output), instantiated twice.

## Test plan
- Reset, `enable`=1, `req_frame` rise → one request at address 0x0. 160 beats land at `lb_waddr` 0x100–0x19F. Then `req_line` rise → `lb_rd_bank`=1, next request at 0x280, writes to 0x000–0x09F.
- Full 480-line frame with zero-stall memory → 480 requests at addresses 0 to 479×640, `fetch_idx` ends at 479, state WAIT_FRAME, no `underrun`.
- Beats stalled so the burst is incomplete at a `req_line` rise → one `underrun` pulse, `lb_rd_bank` unchanged, swap on the next `req_line` rise after the 160th beat.
- `req_frame` rise during BURST at beat 50 → remaining 110 beats are written, then the next request is at 0x0 with `fetch_idx`=0.
- Reset asserted at beat 80 → all outputs 0 the next cycle, stray `mem_rd_valid` produces no `lb_we`, `req_line` rises ignored until a `req_frame` rise.
- `enable`=0 with a `req_frame` rise → no `mem_rd_req`. After `enable`=1, the next `req_frame` rise starts the frame.
